lsu_param: RTL and testbench
============================

Name: lsu_param

Overview:
- Parametrised per-thread load/store unit, successor to the fixed 8-bit LSU; one instance per thread inside each core.
- Issues one memory read or write per instruction during core REQUEST, waits on the valid/ready handshake, and returns load data to the register file.
- New capabilities: configurable address/data widths, a thread-enable gate, an optional response timeout with an ERROR state, and single-operation tracking so a stray ready on the idle channel is ignored.

Parameters:
ADDR_BITS, 8, memory address width
DATA_BITS, 8, memory data and register width
TIMEOUT, 0, maximum WAITING cycles before ERROR; 0 disables the timeout
CNT_BITS, 8, timeout counter width; must satisfy 2^CNT_BITS >= TIMEOUT

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
enable  input  1  thread active; gates new issue only
core_state  input  3  core FSM state; REQUEST=3'b011, UPDATE=3'b110
decoded_mem_read_enable  input  1  current instruction is a load
decoded_mem_write_enable  input  1  current instruction is a store
rs  input  DATA_BITS  address operand
rt  input  DATA_BITS  store data operand
mem_read_valid  output  1  read request valid
mem_read_address  output  ADDR_BITS  read address
mem_read_ready  input  1  read response valid, data on mem_read_data
mem_read_data  input  DATA_BITS  read data
mem_write_valid  output  1  write request valid
mem_write_address  output  ADDR_BITS  write address
mem_write_data  output  DATA_BITS  write data
mem_write_ready  input  1  write accepted
lsu_state  output  2  IDLE=00, WAITING=01, DONE=10, ERROR=11
lsu_out  output  DATA_BITS  last loaded value
lsu_error  output  1  timeout flag

Behaviour:
- Reset (async, any state, mid-transaction included): lsu_state=IDLE; every other output = 0; internal op flag and counter = 0. Any outstanding request is abandoned.
- Address = rs[ADDR_BITS-1:0] when DATA_BITS>=ADDR_BITS, otherwise rs zero-extended.
- IDLE:
  - Issue requires enable=1 and core_state=REQUEST.
  - Load: mem_read_valid<=1; mem_read_address<=addr; op<=READ.
  - Store (and not load): mem_write_valid<=1; mem_write_address<=addr; mem_write_data<=rt; op<=WRITE.
  - Either issue: lsu_state<=WAITING; counter<=0.
  - Load and store both set: load only; no write is issued.
  - Neither set, enable=0, or core_state is not REQUEST: stay IDLE.
- WAITING:
  - Only the ready of the active op is sampled; ready on the other channel is ignored.
  - Address, data and valid stay stable until completion.
  - Active ready=1: clear that valid at the same edge; on READ, lsu_out<=mem_read_data; lsu_state<=DONE.
  - Minimum latency: issue at edge N, ready high in the following cycle, DONE at edge N+1.
  - Ready low: counter increments.
  - TIMEOUT!=0 and counter==TIMEOUT-1 with ready low: clear valid; lsu_error<=1; lsu_state<=ERROR; lsu_out unchanged.
  - If ready arrives in the timeout cycle, ready wins.
- DONE: core_state=UPDATE -> IDLE; otherwise hold.
- ERROR: core_state=UPDATE -> IDLE and lsu_error<=0; otherwise hold with lsu_error=1.
- enable has no effect outside IDLE; an in-flight operation always completes.
- lsu_out changes only on a completed load or reset. Stores never change it.
- Counter saturates and does not wrap when TIMEOUT=0.
- mem_read_valid and mem_write_valid are never high together.

Test Plan:
- Load: rs=0x2A, mem_read_data=0x5C with ready 2 cycles after valid -> mem_read_address=0x2A; valid high exactly 2 cycles; lsu_out=0x5C; DONE until UPDATE, then IDLE.
- Store: rs=0x10, rt=0xEE, ready held high -> write valid/address/data = 1/0x10/0xEE for 1 cycle; DONE; lsu_out keeps its prior value.
- Both enables, plus a spurious mem_write_ready during WAITING -> only the read is issued; the write ready is ignored; state stays WAITING until mem_read_ready.
- TIMEOUT=4, ready never asserted -> valid drops after 4 WAITING cycles; lsu_state=11, lsu_error=1; UPDATE returns IDLE with lsu_error=0.
- ADDR_BITS=6, DATA_BITS=16, rs=0xFFC3 -> mem_read_address=0x03; load of 0xBEEF gives lsu_out=0xBEEF. enable=0 during REQUEST -> no issue.
- Reset asserted asynchronously mid-WAITING (between edges) -> valids, outputs and state clear immediately; a later ready causes no change.

Source files
------------

// File: rtl/lsu_param.sv
// lsu_param -- parametrised per-thread load/store unit.
//
// Issues one memory read (load) or write (store) per instruction while the
// core sits in REQUEST, holds the request until the matching ready arrives,
// and captures load data for the register file. An optional timeout moves
// the unit to ERROR when no response comes back in time.
//
// Ports:
//   clk, reset                  clock (rising edge), async active-high reset
//   enable                      thread active; gates new issue only
//   core_state[2:0]             core FSM state (REQUEST=011, UPDATE=110)
//   decoded_mem_read_enable     current instruction is a load
//   decoded_mem_write_enable    current instruction is a store
//   rs, rt                      address operand, store data operand
//   mem_read_valid/address      read request channel
//   mem_read_ready/data         read response
//   mem_write_valid/address/data  write request channel
//   mem_write_ready             write accepted
//   lsu_state[1:0]              IDLE=00, WAITING=01, DONE=10, ERROR=11
//   lsu_out                     last loaded value
//   lsu_error                   timeout flag
module lsu_param #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8,
    parameter int TIMEOUT   = 0,
    parameter int CNT_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           core_state,
    input  logic                 decoded_mem_read_enable,
    input  logic                 decoded_mem_write_enable,
    input  logic [DATA_BITS-1:0] rs,
    input  logic [DATA_BITS-1:0] rt,
    output logic                 mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    input  logic                 mem_read_ready,
    input  logic [DATA_BITS-1:0] mem_read_data,
    output logic                 mem_write_valid,
    output logic [ADDR_BITS-1:0] mem_write_address,
    output logic [DATA_BITS-1:0] mem_write_data,
    input  logic                 mem_write_ready,
    output logic [1:0]           lsu_state,
    output logic [DATA_BITS-1:0] lsu_out,
    output logic                 lsu_error
);

    localparam logic [2:0] CORE_REQUEST = 3'b011;
    localparam logic [2:0] CORE_UPDATE  = 3'b110;

    // Last WAITING count before giving up; only meaningful when TIMEOUT > 0.
    localparam int unsigned            TO_LAST_I = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
    localparam logic [CNT_BITS-1:0]    TO_LAST   = TO_LAST_I[CNT_BITS-1:0];
    localparam bit                     TO_EN     = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        WAITING = 2'b01,
        DONE    = 2'b10,
        ERROR   = 2'b11
    } state_t;

    // Which channel the in-flight operation uses.
    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    state_t                state_q, state_d;
    op_t                   op_q, op_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
    logic                  rv_q, rv_d;
    logic [ADDR_BITS-1:0]  ra_q, ra_d;
    logic                  wv_q, wv_d;
    logic [ADDR_BITS-1:0]  wa_q, wa_d;
    logic [DATA_BITS-1:0]  wd_q, wd_d;
    logic [DATA_BITS-1:0]  out_q, out_d;
    logic                  err_q, err_d;
    logic [ADDR_BITS-1:0]  addr;
    logic                  active_ready;

    // Truncate the operand when it is wider than the address bus, otherwise
    // zero-extend it.
    generate
        if (DATA_BITS >= ADDR_BITS) begin : g_addr_trunc
            assign addr = rs[ADDR_BITS-1:0];
        end else begin : g_addr_zext
            assign addr = {{(ADDR_BITS-DATA_BITS){1'b0}}, rs};
        end
    endgenerate

    // Only the channel of the operation in flight may complete it.
    assign active_ready = (op_q == OP_WRITE) ? mem_write_ready : mem_read_ready;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        rv_d    = rv_q;
        ra_d    = ra_q;
        wv_d    = wv_q;
        wa_d    = wa_q;
        wd_d    = wd_q;
        out_d   = out_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (enable && (core_state == CORE_REQUEST)) begin
                    // Load takes priority when both decode bits are set.
                    if (decoded_mem_read_enable) begin
                        rv_d    = 1'b1;
                        ra_d    = addr;
                        op_d    = OP_READ;
                        state_d = WAITING;
                        cnt_d   = '0;
                    end else if (decoded_mem_write_enable) begin
                        wv_d    = 1'b1;
                        wa_d    = addr;
                        wd_d    = rt;
                        op_d    = OP_WRITE;
                        state_d = WAITING;
                        cnt_d   = '0;
                    end
                end
            end
            WAITING: begin
                if (active_ready) begin
                    rv_d    = 1'b0;
                    wv_d    = 1'b0;
                    if (op_q == OP_READ) begin
                        out_d = mem_read_data;
                    end
                    state_d = DONE;
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    rv_d    = 1'b0;
                    wv_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = ERROR;
                end else if (cnt_q != {CNT_BITS{1'b1}}) begin
                    // Saturate rather than wrap on very long waits.
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (core_state == CORE_UPDATE) begin
                    state_d = IDLE;
                end
            end
            ERROR: begin
                if (core_state == CORE_UPDATE) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_READ;
            cnt_q   <= '0;
            rv_q    <= 1'b0;
            ra_q    <= '0;
            wv_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            rv_q    <= rv_d;
            ra_q    <= ra_d;
            wv_q    <= wv_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            out_q   <= out_d;
            err_q   <= err_d;
        end
    end

    assign mem_read_valid    = rv_q;
    assign mem_read_address  = ra_q;
    assign mem_write_valid   = wv_q;
    assign mem_write_address = wa_q;
    assign mem_write_data    = wd_q;
    assign lsu_state         = state_q;
    assign lsu_out           = out_q;
    assign lsu_error         = err_q;

endmodule

// File: tb/tb_lsu_param.sv
// Testbench for lsu_param: a default 8/8 instance without timeout driven from
// a per-cycle vector table, and a 6-bit address / 16-bit data instance with
// TIMEOUT=4 driven by hand-written sequences.
module tb_lsu_param;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    // Instance A: defaults.
    logic       a_en, a_rd, a_wr, a_rr, a_wrdy;
    logic [2:0] a_cs;
    logic [7:0] a_rs, a_rt, a_rdat;
    logic       a_rv, a_wv, a_err;
    logic [7:0] a_ra, a_wa, a_wd, a_out;
    logic [1:0] a_st;

    lsu_param u_a (
        .clk(clk), .reset(reset), .enable(a_en), .core_state(a_cs),
        .decoded_mem_read_enable(a_rd), .decoded_mem_write_enable(a_wr),
        .rs(a_rs), .rt(a_rt),
        .mem_read_valid(a_rv), .mem_read_address(a_ra),
        .mem_read_ready(a_rr), .mem_read_data(a_rdat),
        .mem_write_valid(a_wv), .mem_write_address(a_wa),
        .mem_write_data(a_wd), .mem_write_ready(a_wrdy),
        .lsu_state(a_st), .lsu_out(a_out), .lsu_error(a_err)
    );

    // Instance B: narrow address, wide data, timeout of 4 cycles.
    logic        b_en, b_rd, b_wr, b_rr, b_wrdy;
    logic [2:0]  b_cs;
    logic [15:0] b_rs, b_rt, b_rdat;
    logic        b_rv, b_wv, b_err;
    logic [5:0]  b_ra, b_wa;
    logic [15:0] b_wd, b_out;
    logic [1:0]  b_st;

    lsu_param #(.ADDR_BITS(6), .DATA_BITS(16), .TIMEOUT(4), .CNT_BITS(3)) u_b (
        .clk(clk), .reset(reset), .enable(b_en), .core_state(b_cs),
        .decoded_mem_read_enable(b_rd), .decoded_mem_write_enable(b_wr),
        .rs(b_rs), .rt(b_rt),
        .mem_read_valid(b_rv), .mem_read_address(b_ra),
        .mem_read_ready(b_rr), .mem_read_data(b_rdat),
        .mem_write_valid(b_wv), .mem_write_address(b_wa),
        .mem_write_data(b_wd), .mem_write_ready(b_wrdy),
        .lsu_state(b_st), .lsu_out(b_out), .lsu_error(b_err)
    );

    typedef struct {
        logic       en;
        logic [2:0] cs;
        logic       rd, wr;
        logic [7:0] rs, rt;
        logic       rr;
        logic [7:0] rdat;
        logic       wrdy;
        logic       rv;
        logic [7:0] ra;
        logic       wv;
        logic [7:0] wa, wd;
        logic [1:0] st;
        logic [7:0] out;
        logic       err;
    } vec_t;

    vec_t vecs[24];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // {en,cs,rd,wr,rs,rt,rr,rdat,wrdy, rv,ra,wv,wa,wd,st,out,err}
        // Load, ready two cycles after valid.
        vecs[0]  = '{1,3'd3,1,0,8'h2A,8'h00,0,8'h00,0, 1,8'h2A,0,8'h00,8'h00,2'd1,8'h00,0};
        vecs[1]  = '{1,3'd4,1,0,8'h2A,8'h00,0,8'h00,0, 1,8'h2A,0,8'h00,8'h00,2'd1,8'h00,0};
        vecs[2]  = '{1,3'd4,1,0,8'h2A,8'h00,1,8'h5C,0, 0,8'h2A,0,8'h00,8'h00,2'd2,8'h5C,0};
        vecs[3]  = '{1,3'd0,0,0,8'h2A,8'h00,0,8'h00,0, 0,8'h2A,0,8'h00,8'h00,2'd2,8'h5C,0};
        vecs[4]  = '{1,3'd6,0,0,8'h00,8'h00,0,8'h00,0, 0,8'h2A,0,8'h00,8'h00,2'd0,8'h5C,0};
        // Store with ready held high.
        vecs[5]  = '{1,3'd3,0,1,8'h10,8'hEE,0,8'h00,1, 0,8'h2A,1,8'h10,8'hEE,2'd1,8'h5C,0};
        vecs[6]  = '{1,3'd4,0,1,8'h10,8'hEE,0,8'h00,1, 0,8'h2A,0,8'h10,8'hEE,2'd2,8'h5C,0};
        vecs[7]  = '{1,3'd6,0,0,8'h00,8'h00,0,8'h00,0, 0,8'h2A,0,8'h10,8'hEE,2'd0,8'h5C,0};
        // Both decode bits, spurious write ready while waiting on the read.
        vecs[8]  = '{1,3'd3,1,1,8'h33,8'h77,0,8'h00,1, 1,8'h33,0,8'h10,8'hEE,2'd1,8'h5C,0};
        vecs[9]  = '{1,3'd4,1,1,8'h33,8'h77,0,8'h00,1, 1,8'h33,0,8'h10,8'hEE,2'd1,8'h5C,0};
        vecs[10] = '{1,3'd4,1,1,8'h33,8'h77,1,8'hA5,0, 0,8'h33,0,8'h10,8'hEE,2'd2,8'hA5,0};
        vecs[11] = '{1,3'd6,0,0,8'h00,8'h00,0,8'h00,0, 0,8'h33,0,8'h10,8'hEE,2'd0,8'hA5,0};
        // No issue: thread disabled, wrong core state, no decode bit (stray readys).
        vecs[12] = '{0,3'd3,1,0,8'h44,8'h00,0,8'h00,0, 0,8'h33,0,8'h10,8'hEE,2'd0,8'hA5,0};
        vecs[13] = '{1,3'd2,1,0,8'h44,8'h00,0,8'h00,0, 0,8'h33,0,8'h10,8'hEE,2'd0,8'hA5,0};
        vecs[14] = '{1,3'd3,0,0,8'h44,8'h00,1,8'h99,1, 0,8'h33,0,8'h10,8'hEE,2'd0,8'hA5,0};
        // enable dropped mid-flight: the load still completes.
        vecs[15] = '{1,3'd3,1,0,8'h55,8'h00,0,8'h00,0, 1,8'h55,0,8'h10,8'hEE,2'd1,8'hA5,0};
        vecs[16] = '{0,3'd4,1,0,8'h55,8'h00,0,8'h00,0, 1,8'h55,0,8'h10,8'hEE,2'd1,8'hA5,0};
        vecs[17] = '{0,3'd4,0,0,8'h55,8'h00,1,8'h3C,0, 0,8'h55,0,8'h10,8'hEE,2'd2,8'h3C,0};
        vecs[18] = '{0,3'd6,0,0,8'h00,8'h00,0,8'h00,0, 0,8'h55,0,8'h10,8'hEE,2'd0,8'h3C,0};
        // Store ignores read ready; DONE does not re-issue on REQUEST.
        vecs[19] = '{1,3'd3,0,1,8'h20,8'h11,0,8'h00,0, 0,8'h55,1,8'h20,8'h11,2'd1,8'h3C,0};
        vecs[20] = '{1,3'd4,0,1,8'h20,8'h11,1,8'hFF,0, 0,8'h55,1,8'h20,8'h11,2'd1,8'h3C,0};
        vecs[21] = '{1,3'd4,0,1,8'h20,8'h11,0,8'h00,1, 0,8'h55,0,8'h20,8'h11,2'd2,8'h3C,0};
        vecs[22] = '{1,3'd3,1,0,8'h66,8'h00,0,8'h00,0, 0,8'h55,0,8'h20,8'h11,2'd2,8'h3C,0};
        vecs[23] = '{1,3'd6,0,0,8'h00,8'h00,0,8'h00,0, 0,8'h55,0,8'h20,8'h11,2'd0,8'h3C,0};

        reset = 1'b1;
        {a_en, a_rd, a_wr, a_rr, a_wrdy} = '0;
        a_cs = '0; a_rs = '0; a_rt = '0; a_rdat = '0;
        {b_en, b_rd, b_wr, b_rr, b_wrdy} = '0;
        b_cs = '0; b_rs = '0; b_rt = '0; b_rdat = '0;

        step();
        step();
        chk("reset_a", {a_rv, a_ra, a_wv, a_wa, a_wd, a_st, a_out, a_err}, 64'd0);
        chk("reset_b", {b_rv, b_ra, b_wv, b_wa, b_wd, b_st, b_out, b_err}, 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 24; i++) begin
            a_en = vecs[i].en;   a_cs = vecs[i].cs;
            a_rd = vecs[i].rd;   a_wr = vecs[i].wr;
            a_rs = vecs[i].rs;   a_rt = vecs[i].rt;
            a_rr = vecs[i].rr;   a_rdat = vecs[i].rdat;
            a_wrdy = vecs[i].wrdy;
            step();
            chk($sformatf("vec%0d", i),
                {27'd0, a_rv, a_ra, a_wv, a_wa, a_wd, a_st, a_out, a_err},
                {27'd0, vecs[i].rv, vecs[i].ra, vecs[i].wv, vecs[i].wa, vecs[i].wd,
                 vecs[i].st, vecs[i].out, vecs[i].err});
        end

        // Long wait with timeout disabled: no error, request stays up.
        a_en = 1; a_cs = 3'd3; a_rd = 1; a_wr = 0; a_rs = 8'h77; a_rr = 0; a_wrdy = 0;
        step();
        a_cs = 3'd4;
        for (int k = 0; k < 300; k++) step();
        chk("a_long_wait", {a_st, a_rv, a_err, a_ra}, {2'd1, 1'b1, 1'b0, 8'h77});
        a_rr = 1; a_rdat = 8'h81;
        step();
        chk("a_long_done", {a_st, a_rv, a_out}, {2'd2, 1'b0, 8'h81});
        a_rr = 0; a_cs = 3'd6;
        step();
        chk("a_long_idle", a_st, 2'd0);

        // Instance B: address truncation and wide load.
        b_en = 1; b_cs = 3'd3; b_rd = 1; b_rs = 16'hFFC3;
        step();
        chk("b_trunc_addr", {b_st, b_rv, b_ra}, {2'd1, 1'b1, 6'h03});
        b_cs = 3'd4; b_rd = 0; b_rr = 1; b_rdat = 16'hBEEF;
        step();
        chk("b_load_done", {b_st, b_rv, b_out, b_err}, {2'd2, 1'b0, 16'hBEEF, 1'b0});
        b_rr = 0; b_cs = 3'd6;
        step();
        chk("b_load_idle", b_st, 2'd0);

        // enable=0 during REQUEST: nothing issued.
        b_en = 0; b_cs = 3'd3; b_rd = 1; b_rs = 16'h0005;
        step();
        chk("b_disabled", {b_st, b_rv, b_ra}, {2'd0, 1'b0, 6'h03});

        // Timeout: valid held for exactly 4 WAITING cycles.
        b_en = 1;
        step();
        chk("b_to_issue", {b_st, b_rv, b_ra}, {2'd1, 1'b1, 6'h05});
        b_cs = 3'd4; b_rd = 0;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk($sformatf("b_to_wait%0d", k), {b_st, b_rv, b_err}, {2'd1, 1'b1, 1'b0});
        end
        step();
        chk("b_to_error", {b_st, b_rv, b_err, b_out}, {2'd3, 1'b0, 1'b1, 16'hBEEF});
        step();
        chk("b_to_hold", {b_st, b_err}, {2'd3, 1'b1});
        b_cs = 3'd6;
        step();
        chk("b_to_clear", {b_st, b_err}, {2'd0, 1'b0});

        // Ready arriving in the timeout cycle wins (store path).
        b_cs = 3'd3; b_wr = 1; b_rs = 16'h0009; b_rt = 16'h1234;
        step();
        chk("b_st_issue", {b_st, b_wv, b_wa, b_wd}, {2'd1, 1'b1, 6'h09, 16'h1234});
        b_cs = 3'd4; b_wr = 0;
        for (int k = 0; k < 3; k++) step();
        b_wrdy = 1;
        step();
        chk("b_st_lastcycle", {b_st, b_wv, b_err, b_out}, {2'd2, 1'b0, 1'b0, 16'hBEEF});
        b_wrdy = 0; b_cs = 3'd6;
        step();
        chk("b_st_idle", b_st, 2'd0);

        // Asynchronous reset between edges while WAITING.
        b_cs = 3'd3; b_rd = 1; b_rs = 16'h002A;
        step();
        chk("b_rst_issue", {b_st, b_rv}, {2'd1, 1'b1});
        b_cs = 3'd4; b_rd = 0;
        #2;
        reset = 1'b1;
        #1;
        chk("b_async_rst", {b_rv, b_ra, b_wv, b_wa, b_wd, b_st, b_out, b_err}, 64'd0);
        step();
        reset = 1'b0;
        b_rr = 1; b_rdat = 16'h7777;
        step();
        chk("b_post_rst_ready", {b_st, b_rv, b_out}, {2'd0, 1'b0, 16'h0000});

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
